// File: rtl/dpsram_arbiter_if.sv
// rtl/dpsram_arbiter_if.sv - requester-side request/grant/response bus of the shared SRAM arbiter
interface dpsram_arbiter_if #(
   parameter int SRAM_LENGTH = 8,
   parameter int SRAM_DEPTH  = 16,
   parameter int NUM_REQ     = 4
);
   localparam int AW = $clog2(SRAM_DEPTH);

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             req_we;
   logic [NUM_REQ*AW-1:0]          req_addr;
   logic [NUM_REQ*SRAM_LENGTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic [NUM_REQ*SRAM_LENGTH-1:0] rsp_data;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  gnt, rsp_valid, rsp_data
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output gnt, rsp_valid, rsp_data
   );
endinterface

// File: rtl/dpsram_arbiter.sv
// rtl/dpsram_arbiter.sv - round-robin two-port arbiter with zero-fill for one dual-port SRAM
module dpsram_arbiter #(
   parameter int SRAM_LENGTH = 8,
   parameter int SRAM_DEPTH  = 16,
   parameter int NUM_REQ     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   output logic                          init_done,
   dpsram_arbiter_if.slave               bus,
   output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr1,
   output logic [$clog2(SRAM_DEPTH)-1:0] sram_addr2,
   output logic [SRAM_LENGTH-1:0]        sram_din1,
   output logic [SRAM_LENGTH-1:0]        sram_din2,
   output logic                          sram_wen1,
   output logic                          sram_wen2,
   input  logic [SRAM_LENGTH-1:0]        sram_dout1,
   input  logic [SRAM_LENGTH-1:0]        sram_dout2
);
   localparam int AW = $clog2(SRAM_DEPTH);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                 state, state_n;
   logic [AW-1:0]          cnt, cnt_n;
   logic [IW-1:0]          rr_ptr, rr_n;
   logic [AW:0]            fill_a1, fill_a2;
   logic [AW-1:0]          addr_a  [NUM_REQ];
   logic [SRAM_LENGTH-1:0] wdata_a [NUM_REQ];
   logic                   p1_vld, p2_vld;
   logic [IW-1:0]          p1, p2, cand;
   logic [IW:0]            sum;
   logic                   use1, use2;
   logic                   wen1, wen2;
   logic [AW-1:0]          a1, a2;
   logic [SRAM_LENGTH-1:0] d1, d2;
   logic [AW-1:0]          addr1_q, addr2_q;
   logic [SRAM_LENGTH-1:0] din1_q, din2_q;
   logic                   own1_vld, own2_vld;
   logic [IW-1:0]          own1, own2;
   logic [NUM_REQ-1:0]     rsp_valid_q;

   // Unpack the per-requester address and write-data slices
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_a[i]  = bus.req_addr[i*AW +: AW];
         wdata_a[i] = bus.req_wdata[i*SRAM_LENGTH +: SRAM_LENGTH];
      end
   end

   // Next state: zero-fill sequencing in INIT, round-robin two-port arbitration in RUN
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rr_n      = rr_ptr;
      p1_vld    = 1'b0;
      p2_vld    = 1'b0;
      p1        = '0;
      p2        = '0;
      cand      = '0;
      sum       = '0;
      use1      = 1'b0;
      use2      = 1'b0;
      wen1      = 1'b0;
      wen2      = 1'b0;
      a1        = '0;
      a2        = '0;
      d1        = '0;
      d2        = '0;
      bus.gnt   = '0;
      init_done = (state == S_RUN);
      fill_a1   = {cnt, 1'b0};
      fill_a2   = fill_a1 + (AW+1)'(1);
      case (state)
         S_INIT: begin
            use1  = 1'b1;
            wen1  = 1'b1;
            a1    = fill_a1[AW-1:0];
            // with an odd depth the last pair has no second word
            use2  = (fill_a2 <= (AW+1)'(SRAM_DEPTH-1));
            wen2  = use2;
            a2    = fill_a2[AW-1:0];
            cnt_n = cnt + AW'(1);
            if (fill_a2 >= (AW+1)'(SRAM_DEPTH-1)) begin
               state_n = S_RUN;
               cnt_n   = '0;
            end
         end
         default: begin
            for (int k = 0; k < NUM_REQ; k++) begin
               sum = {1'b0, rr_ptr} + (IW+1)'(k);
               if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
               cand = sum[IW-1:0];
               if (!p1_vld && bus.req[cand]) begin
                  p1_vld = 1'b1;
                  p1     = cand;
               end
            end
            // port 2 continues the scan past the port 1 winner, skipping write hazards
            for (int k = 1; k < NUM_REQ; k++) begin
               sum = {1'b0, p1} + (IW+1)'(k);
               if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
               cand = sum[IW-1:0];
               if (p1_vld && !p2_vld && bus.req[cand] &&
                   !((addr_a[cand] == addr_a[p1]) && (bus.req_we[cand] || bus.req_we[p1]))) begin
                  p2_vld = 1'b1;
                  p2     = cand;
               end
            end
            if (p1_vld) begin
               bus.gnt[p1] = 1'b1;
               use1        = 1'b1;
               wen1        = bus.req_we[p1];
               a1          = addr_a[p1];
               d1          = wdata_a[p1];
               sum         = {1'b0, p1} + (IW+1)'(1);
            end
            if (p2_vld) begin
               bus.gnt[p2] = 1'b1;
               use2        = 1'b1;
               wen2        = bus.req_we[p2];
               a2          = addr_a[p2];
               d2          = wdata_a[p2];
               sum         = {1'b0, p2} + (IW+1)'(1);
            end
            if (p1_vld) begin
               if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
               rr_n = sum[IW-1:0];
            end
            // grants of the clear cycle still complete; their responses arrive during INIT
            if (clear) begin
               state_n = S_INIT;
               cnt_n   = '0;
            end
         end
      endcase
   end

   // Idle ports keep their last address and data, only the write enable drops
   assign sram_wen1  = wen1;
   assign sram_wen2  = wen2;
   assign sram_addr1 = use1 ? a1 : addr1_q;
   assign sram_addr2 = use2 ? a2 : addr2_q;
   assign sram_din1  = use1 ? d1 : din1_q;
   assign sram_din2  = use2 ? d2 : din2_q;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_INIT;
      else        state <= state_n;
   end

   // Fill counter, round-robin pointer, port owners and held port values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         rr_ptr      <= '0;
         rsp_valid_q <= '0;
         own1_vld    <= 1'b0;
         own2_vld    <= 1'b0;
         own1        <= '0;
         own2        <= '0;
         addr1_q     <= '0;
         addr2_q     <= '0;
         din1_q      <= '0;
         din2_q      <= '0;
      end else begin
         cnt         <= cnt_n;
         rr_ptr      <= rr_n;
         rsp_valid_q <= bus.gnt;
         own1_vld    <= p1_vld;
         own2_vld    <= p2_vld;
         own1        <= p1;
         own2        <= p2;
         if (use1) begin
            addr1_q <= a1;
            din1_q  <= d1;
         end
         if (use2) begin
            addr2_q <= a2;
            din2_q  <= d2;
         end
      end
   end

   // Route each port's registered SRAM output to the requester it served last cycle
   always_comb begin
      bus.rsp_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (own1_vld && own1 == IW'(i))
            bus.rsp_data[i*SRAM_LENGTH +: SRAM_LENGTH] = sram_dout1;
         else if (own2_vld && own2 == IW'(i))
            bus.rsp_data[i*SRAM_LENGTH +: SRAM_LENGTH] = sram_dout2;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
endmodule

// File: tb/tb_dpsram_arbiter.sv
// tb/tb_dpsram_arbiter.sv - scoreboard bench for the dual-port SRAM arbiter
module tb_dpsram_arbiter;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int NR    = 4;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          init_done;
   logic [AW-1:0] sram_addr1, sram_addr2;
   logic [DW-1:0] sram_din1, sram_din2;
   logic          sram_wen1, sram_wen2;
   logic [DW-1:0] sram_dout1, sram_dout2;
   logic [DW-1:0] mem [DEPTH];

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] exp_q [NR][$];

   dpsram_arbiter_if #(.SRAM_LENGTH(DW), .SRAM_DEPTH(DEPTH), .NUM_REQ(NR)) bus ();

   dpsram_arbiter #(.SRAM_LENGTH(DW), .SRAM_DEPTH(DEPTH), .NUM_REQ(NR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .init_done  (init_done),
      .bus        (bus.slave),
      .sram_addr1 (sram_addr1),
      .sram_addr2 (sram_addr2),
      .sram_din1  (sram_din1),
      .sram_din2  (sram_din2),
      .sram_wen1  (sram_wen1),
      .sram_wen2  (sram_wen2),
      .sram_dout1 (sram_dout1),
      .sram_dout2 (sram_dout2)
   );

   always #5 clk = ~clk;

   // Dual-port SRAM: registered read, write-through on write; starts with non-zero contents
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
      sram_dout1 = '0;
      sram_dout2 = '0;
      forever begin
         @(posedge clk);
         if (sram_wen1) begin
            mem[sram_addr1] <= sram_din1;
            sram_dout1      <= sram_din1;
         end else begin
            sram_dout1 <= mem[sram_addr1];
         end
         if (sram_wen2) begin
            mem[sram_addr2] <= sram_din2;
            sram_dout2      <= sram_din2;
         end else begin
            sram_dout2 <= mem[sram_addr2];
         end
      end
   end

   // Response monitor: pops the expected data for every valid response slice
   initial begin
      logic [DW-1:0] got, want;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
               if (bus.rsp_valid[i]) begin
                  got   = bus.rsp_data[i*DW +: DW];
                  total = total + 1;
                  if (exp_q[i].size() == 0) begin
                     bad = bad + 1;
                     $display("FAIL rsp_unexpected[%0d] got=%h required=none", i, got);
                  end else begin
                     want = exp_q[i].pop_front();
                     if (got !== want) begin
                        bad = bad + 1;
                        $display("FAIL rsp_data[%0d] got=%h required=%h", i, got, want);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total = total + 1;
      if (got !== want) begin
         bad = bad + 1;
         $display("FAIL %s got=%h required=%h", name, got, want);
      end
   endtask

   // One request cycle: check the grant and queue the expected responses
   task automatic drive(input logic [3:0] r, input logic [3:0] we, input logic [15:0] a,
                        input logic [31:0] wd, input logic [3:0] eg, input logic [31:0] ed,
                        input string name);
      bus.req       = r;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      @(negedge clk);
      chk(name, 64'(bus.gnt), 64'(eg));
      for (int i = 0; i < NR; i++)
         if (eg[i]) exp_q[i].push_back(ed[i*DW +: DW]);
      @(posedge clk);
      #1;
      bus.req = '0;
   endtask

   // Eight zero-fill cycles: word pairs (2k, 2k+1), no grants
   task automatic check_init(input string name);
      for (int k = 0; k < DEPTH/2; k++) begin
         @(negedge clk);
         chk(name,
             64'({init_done, bus.gnt, sram_wen1, sram_wen2, sram_addr1, sram_addr2, sram_din1, sram_din2}),
             64'({1'b0, 4'b0000, 1'b1, 1'b1, 4'(2*k), 4'(2*k+1), 16'h0000}));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      clear         = 1'b0;
      bus.req       = 4'b1111;
      bus.req_we    = 4'b0000;
      bus.req_addr  = 16'h3210;
      bus.req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 64'({init_done, bus.gnt, bus.rsp_valid, bus.rsp_data}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_init("fill_after_reset");
      bus.req = '0;
      @(negedge clk);
      chk("init_done_after_reset", 64'(init_done), 64'd1);
      @(posedge clk);
      #1;

      drive(4'b0011, 4'b0000, 16'h0049, 32'h0,        4'b0011, 32'h00000000, "c1_two_reads");
      drive(4'b0001, 4'b0001, 16'h0003, 32'h000000A5, 4'b0001, 32'h000000A5, "c2_write_a5");
      drive(4'b0010, 4'b0000, 16'h0030, 32'h0,        4'b0010, 32'h0000A500, "c3_read_a5");
      drive(4'b1111, 4'b0000, 16'h3A98, 32'h0,        4'b1100, 32'hA5000000, "c4_rr_23");
      drive(4'b1111, 4'b0000, 16'h3A98, 32'h0,        4'b0011, 32'h00000000, "c5_rr_01");
      drive(4'b1111, 4'b0000, 16'h3A98, 32'h0,        4'b1100, 32'hA5000000, "c6_rr_23");
      drive(4'b0111, 4'b0001, 16'h0655, 32'h0000005C, 4'b0101, 32'h0000005C, "c7_raw_hazard");
      drive(4'b0010, 4'b0000, 16'h0050, 32'h0,        4'b0010, 32'h00005C00, "c8_read_after_write");
      drive(4'b1100, 4'b1000, 16'h7700, 32'h3C000000, 4'b0100, 32'h00000000, "c9_war_hazard");
      drive(4'b1000, 4'b1000, 16'h7000, 32'h3C000000, 4'b1000, 32'h3C000000, "c10_write_3c");
      drive(4'b1100, 4'b0000, 16'h7700, 32'h0,        4'b1100, 32'h3C3C0000, "c11_same_addr_reads");
      drive(4'b0010, 4'b0000, 16'h0030, 32'h0,        4'b0010, 32'h0000A500, "c12_regrant_a");
      drive(4'b0010, 4'b0000, 16'h0030, 32'h0,        4'b0010, 32'h0000A500, "c13_regrant_b");
      drive(4'b1001, 4'b0000, 16'hF001, 32'h0,        4'b1001, 32'h00000000, "c14_wrap");
      drive(4'b0011, 4'b0011, 16'h0022, 32'h00002211, 4'b0010, 32'h00002200, "c15_waw_hazard");
      drive(4'b0001, 4'b0001, 16'h0002, 32'h00000011, 4'b0001, 32'h00000011, "c16_write_11");

      clear = 1'b1;
      drive(4'b0010, 4'b0000, 16'h0030, 32'h0,        4'b0010, 32'h0000A500, "c17_clear_grant");
      clear = 1'b0;
      bus.req      = 4'b0010;
      bus.req_we   = 4'b0000;
      bus.req_addr = 16'h0030;
      check_init("fill_after_clear");
      bus.req = '0;
      @(negedge clk);
      chk("init_done_after_clear", 64'(init_done), 64'd1);
      @(posedge clk);
      #1;
      drive(4'b0011, 4'b0000, 16'h0032, 32'h0,        4'b0011, 32'h00000000, "c18_rezeroed");

      repeat (3) @(posedge clk);
      for (int i = 0; i < NR; i++)
         chk($sformatf("pending_rsp[%0d]", i), 64'(exp_q[i].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
